// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO: any depth >= 2, threshold flags,
// registered status pulses, occupancy count and optional FWFT read.
module fifo_sync_param #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_TH      = FIFO_DEPTH - 1,
  parameter int AE_TH      = 1,
  parameter int FWFT       = 0,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic [CNT_W-1:0]      count
);

  localparam int PTR_W =
    (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST =
    PTR_W'(FIFO_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_ack_q, wr_ack_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             wr_accept, rd_accept;

  assign full        = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty       = (count_q == '0);
  assign almostfull  = (count_q >= CNT_W'(AF_TH));
  assign almostempty = (count_q <= CNT_W'(AE_TH));
  assign count       = count_q;
  assign wr_ack      = wr_ack_q;
  assign overflow    = ovf_q;
  assign underflow   = udf_q;

  // Pre-edge flags only: a same-cycle read never frees room for a write
  assign wr_accept = wr_en & ~full;
  assign rd_accept = rd_en & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wr_ack_d = wr_accept;
    ovf_d    = wr_en & full;
    udf_d    = rd_en & empty;
    if (wr_accept)
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ?
        '0 : wr_ptr_q + PTR_W'(1);
    if (rd_accept)
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ?
        '0 : rd_ptr_q + PTR_W'(1);
    unique case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wr_ack_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wr_ack_q <= wr_ack_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept)
      mem_q[wr_ptr_q] <= din;
  end

  if (FWFT != 0) begin : g_fwft
    assign dout = empty ? '0 : mem_q[rd_ptr_q];
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        dout_q <= '0;
      else if (rd_accept)
        dout_q <= mem_q[rd_ptr_q];
    end
    assign dout = dout_q;
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: vector table, corner sequences and
// randomized traffic against a queue-based reference.
module tb_fifo_sync_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        s_wr = 0, s_rd = 0;
  logic [15:0] s_din = '0, s_dout;
  logic        s_full, s_empty, s_af, s_ae;
  logic        s_ack, s_ovf, s_udf;
  logic [3:0]  s_cnt;

  logic        w_wr = 0, w_rd = 0;
  logic [15:0] w_din = '0, w_dout;
  logic        w_full, w_empty, w_af, w_ae;
  logic        w_ack, w_ovf, w_udf;
  logic [2:0]  w_cnt;

  logic        f_wr = 0, f_rd = 0;
  logic [15:0] f_din = '0, f_dout;
  logic        f_full, f_empty, f_af, f_ae;
  logic        f_ack, f_ovf, f_udf;
  logic [3:0]  f_cnt;

  fifo_sync_param #(
    .DATA_WIDTH(16), .FIFO_DEPTH(8), .FWFT(0)
  ) u_std (
    .clk(clk), .rst(rst), .wr_en(s_wr), .rd_en(s_rd),
    .din(s_din), .dout(s_dout), .full(s_full),
    .empty(s_empty), .almostfull(s_af),
    .almostempty(s_ae), .wr_ack(s_ack),
    .overflow(s_ovf), .underflow(s_udf), .count(s_cnt)
  );

  fifo_sync_param #(
    .DATA_WIDTH(16), .FIFO_DEPTH(5), .FWFT(0)
  ) u_wrap (
    .clk(clk), .rst(rst), .wr_en(w_wr), .rd_en(w_rd),
    .din(w_din), .dout(w_dout), .full(w_full),
    .empty(w_empty), .almostfull(w_af),
    .almostempty(w_ae), .wr_ack(w_ack),
    .overflow(w_ovf), .underflow(w_udf), .count(w_cnt)
  );

  fifo_sync_param #(
    .DATA_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1)
  ) u_fwft (
    .clk(clk), .rst(rst), .wr_en(f_wr), .rd_en(f_rd),
    .din(f_din), .dout(f_dout), .full(f_full),
    .empty(f_empty), .almostfull(f_af),
    .almostempty(f_ae), .wr_ack(f_ack),
    .overflow(f_ovf), .underflow(f_udf), .count(f_cnt)
  );

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] din;
    logic [3:0]  cnt;
    logic [15:0] dout;
    logic [6:0]  fl;
  } vec_t;

  vec_t tbl[$];

  // {full, empty, almostfull, almostempty, ack, ovf, udf}
  function automatic logic [6:0] flags(int cnt, int depth,
      logic ack, logic ovf, logic udf);
    return {cnt == depth, cnt == 0, cnt >= depth - 1,
            cnt <= 1, ack, ovf, udf};
  endfunction

  function automatic void add(logic wr, logic rd,
      int din, int cnt, int dout,
      logic ack, logic ovf, logic udf);
    vec_t v;
    v.wr   = wr;
    v.rd   = rd;
    v.din  = 16'(din);
    v.cnt  = 4'(cnt);
    v.dout = 16'(dout);
    v.fl   = flags(cnt, 8, ack, ovf, udf);
    tbl.push_back(v);
  endfunction

  task automatic chk(string name, logic [63:0] act,
      logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  function automatic logic [26:0] s_vec();
    return {s_cnt, s_dout, s_full, s_empty, s_af, s_ae,
            s_ack, s_ovf, s_udf};
  endfunction

  logic [15:0] got[$];
  logic [15:0] qw[$];
  logic [15:0] qf[$];
  logic [15:0] exp_dw;
  logic        wa, ra, bw, br;
  int          bias;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_state", 64'(s_vec()),
        64'({4'd0, 16'h0, flags(0, 8, 0, 0, 0)}));

    // activity then asynchronous reset between edges
    s_wr = 1; s_din = 16'h1111; step();
    s_din = 16'h2222; step();
    s_wr = 0; s_rd = 1; step();
    s_rd = 0; s_wr = 1; s_din = 16'h3333; step();
    chk("pre_async_rst", 64'({s_cnt, s_dout, s_ack}),
        64'({4'd2, 16'h1111, 1'b1}));
    s_wr = 0;
    #3 rst = 1'b1;
    #1;
    chk("async_rst", 64'({s_cnt, s_dout, s_empty,
        s_full, s_ack}), 64'({4'd0, 16'h0, 3'b100}));
    rst = 1'b0;
    s_wr = 1;
    for (int i = 0; i < 3; i++) begin
      s_din = 16'(i + 1);
      step();
    end
    s_wr = 0;
    chk("three_writes", 64'(s_cnt), 64'd3);
    do_reset();

    for (int i = 1; i <= 8; i++)
      add(1, 0, i, i, 0, 1, 0, 0);
    add(1, 0, 'hDEAD, 8, 0, 0, 1, 0);
    add(0, 0, 0, 8, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++)
      add(0, 1, 0, 8 - i, i, 0, 0, 0);
    add(0, 1, 0, 0, 8, 0, 0, 1);
    add(0, 0, 0, 0, 8, 0, 0, 0);
    for (int i = 1; i <= 8; i++)
      add(1, 0, 'h100 + i, i, 8, 1, 0, 0);
    add(1, 1, 'hBEEF, 7, 'h101, 0, 1, 0);
    for (int i = 2; i <= 8; i++)
      add(0, 1, 0, 8 - i, 'h100 + i, 0, 0, 0);
    add(1, 1, 'hC0, 1, 'h108, 1, 0, 1);
    for (int i = 1; i <= 3; i++)
      add(1, 0, 'hC0 + i, 1 + i, 'h108, 1, 0, 0);
    for (int i = 0; i < 10; i++)
      add(1, 1, 'hD0 + i, 4,
          (i < 4) ? 'hC0 + i : 'hD0 + i - 4, 1, 0, 0);
    for (int i = 0; i < 4; i++)
      add(0, 1, 0, 3 - i, 'hD6 + i, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      s_wr  = tbl[i].wr;
      s_rd  = tbl[i].rd;
      s_din = tbl[i].din;
      step();
      chk($sformatf("vec%0d", i), 64'(s_vec()),
          64'({tbl[i].cnt, tbl[i].dout, tbl[i].fl}));
    end
    s_wr = 0;
    s_rd = 0;

    // depth 5: 12 words through, pointers wrap twice
    w_wr = 1;
    for (int i = 0; i < 12; i++) begin
      w_rd  = (i >= 3);
      w_din = 16'(16'h10 + i);
      step();
      if (w_rd) got.push_back(w_dout);
    end
    w_wr = 0;
    w_rd = 1;
    repeat (3) begin
      step();
      got.push_back(w_dout);
    end
    w_rd = 0;
    chk("wrap_len", 64'(got.size()), 64'd12);
    for (int i = 0; i < got.size(); i++)
      chk($sformatf("wrap%0d", i), 64'(got[i]),
          64'(16'h10 + i));
    chk("wrap_empty", 64'({w_cnt, w_empty}), 64'({3'd0, 1'b1}));

    chk("fwft_idle", 64'({f_dout, f_empty}),
        64'({16'h0, 1'b1}));
    f_wr = 1; f_din = 16'hA5A5; step();
    f_wr = 0;
    chk("fwft_show", 64'({f_dout, f_cnt}),
        64'({16'hA5A5, 4'd1}));
    f_wr = 1; f_din = 16'h5A5A; step();
    f_wr = 0;
    chk("fwft_hold", 64'({f_dout, f_cnt}),
        64'({16'hA5A5, 4'd2}));
    f_rd = 1; step();
    chk("fwft_next", 64'({f_dout, f_cnt}),
        64'({16'h5A5A, 4'd1}));
    step();
    f_rd = 0;
    chk("fwft_drain", 64'({f_dout, f_empty, f_udf}),
        64'({16'h0, 1'b1, 1'b0}));

    do_reset();
    exp_dw = '0;
    for (int c = 0; c < 600; c++) begin
      bias  = ((c / 40) % 2 == 1) ? 3 : 1;
      w_wr  = ($urandom_range(0, 3) < bias);
      w_rd  = ($urandom_range(0, 3) < 4 - bias);
      w_din = 16'($urandom);
      f_wr  = ($urandom_range(0, 3) < bias);
      f_rd  = ($urandom_range(0, 3) < 4 - bias);
      f_din = 16'($urandom);

      bw = w_wr && (qw.size() == 5);
      br = w_rd && (qw.size() == 0);
      wa = w_wr && !bw;
      ra = w_rd && !br;
      if (ra) exp_dw = qw.pop_front();
      if (wa) qw.push_back(w_din);
      step();
      chk($sformatf("rnd_w%0d", c),
          64'({w_cnt, w_dout, w_full, w_empty, w_af,
               w_ae, w_ack, w_ovf, w_udf}),
          64'({3'(qw.size()), exp_dw,
               flags(qw.size(), 5, wa, bw, br)}));

      bw = f_wr && (qf.size() == 8);
      br = f_rd && (qf.size() == 0);
      if (f_rd && !br) void'(qf.pop_front());
      if (f_wr && !bw) qf.push_back(f_din);
      chk($sformatf("rnd_f%0d", c),
          64'({f_cnt, f_dout, f_full, f_empty, f_af,
               f_ae, f_ack, f_ovf, f_udf}),
          64'({4'(qf.size()),
               (qf.size() != 0) ? qf[0] : 16'h0,
               flags(qf.size(), 8, f_wr && !bw, bw, br)}));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
